// File: rtl/data_queue_credit_return_pkg.sv
// Shared types and defaults for the MMU data queue with batched credit return.
package data_queue_credit_return_pkg;

    localparam int DEF_DATA_BITS  = 512;
    localparam int DEF_DEPTH      = 64;
    localparam int DEF_CRED_BATCH = 8;

    // Counts must represent 0..DEPTH inclusive, hence one bit beyond the pointer width.
    function automatic int cnt_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int DEF_CNT_BITS = $clog2(DEF_DEPTH) + 1;

    typedef logic [DEF_CNT_BITS-1:0] cred_cnt_t;

    typedef enum logic {
        CRED_IDLE = 1'b0,
        CRED_PEND = 1'b1
    } cred_state_t;

endpackage

// File: rtl/data_queue_credit_return_fifo.sv
// First-word-fall-through FIFO over a simple dual-port RAM (sync write, async read).
module data_queue_fifo_sdp
    import data_queue_credit_return_pkg::*;
#(
    parameter int WIDTH     = 577,
    parameter int DEPTH     = DEF_DEPTH,
    localparam int CNT_BITS = cnt_bits(DEPTH),
    localparam int PTR_BITS = $clog2(DEPTH)
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                wr_en,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                rd_en,
    output logic [WIDTH-1:0]    rd_data,
    output logic                full,
    output logic                empty,
    output logic [CNT_BITS-1:0] occupancy
);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [CNT_BITS-1:0] count;
    logic                do_wr;
    logic                do_rd;

    // Full is decoded from the registered count, so a read in the full cycle
    // cannot reopen the write side until the next cycle.
    assign full      = (count == CNT_BITS'(DEPTH));
    assign empty     = (count == '0);
    assign occupancy = count;
    assign do_wr     = wr_en & ~full;
    assign do_rd     = rd_en & ~empty;
    assign rd_data   = mem[rd_ptr];

    always_ff @(posedge aclk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_queue_credit_return.sv
// AXI4-Stream data queue that returns drained beats upstream as batched credits.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   CRED_IDLE | no credit on the return channel; a load may issue freely
//   CRED_PEND | cred_cnt presented with cred_valid, waiting for cred_ready
module data_queue_credit_return
    import data_queue_credit_return_pkg::*;
#(
    parameter int DATA_BITS     = DEF_DATA_BITS,
    parameter int DEPTH         = DEF_DEPTH,
    parameter int CRED_BATCH    = DEF_CRED_BATCH,
    parameter int FLUSH_ON_LAST = 1,
    localparam int CNT_BITS     = cnt_bits(DEPTH)
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [DATA_BITS-1:0]   s_axis_tdata,
    input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
    input  logic                   s_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [DATA_BITS-1:0]   m_axis_tdata,
    output logic [DATA_BITS/8-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   wxfer,
    output logic                   rxfer,
    output logic                   cred_valid,
    input  logic                   cred_ready,
    output logic [CNT_BITS-1:0]    cred_cnt,
    output logic [CNT_BITS-1:0]    occupancy,
    output logic                   cred_ovf
);

    localparam int WIDTH = DATA_BITS + DATA_BITS/8 + 1;
    localparam logic [CNT_BITS-1:0] ACC_MAX = '1;
    localparam logic [CNT_BITS-1:0] BATCH   = CNT_BITS'(CRED_BATCH);

    logic [WIDTH-1:0]    wr_word;
    logic [WIDTH-1:0]    rd_word;
    logic                full;
    logic                empty;
    logic [CNT_BITS-1:0] acc;
    logic [CNT_BITS-1:0] acc_next;
    logic                acc_sat;
    logic                slot_free;
    logic                flush_hit;
    logic                load;
    cred_state_t         state;

    assign s_axis_tready = ~full;
    assign m_axis_tvalid = ~empty;
    assign wxfer         = s_axis_tvalid & s_axis_tready;
    assign rxfer         = m_axis_tvalid & m_axis_tready;
    assign wr_word       = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = rd_word;

    data_queue_fifo_sdp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .wr_en     (wxfer),
        .wr_data   (wr_word),
        .rd_en     (rxfer),
        .rd_data   (rd_word),
        .full      (full),
        .empty     (empty),
        .occupancy (occupancy)
    );

    // acc_next folds in this cycle's drain so a load never drops the beat in flight.
    always_comb begin
        acc_sat   = rxfer && (acc == ACC_MAX);
        acc_next  = acc_sat ? acc : acc + CNT_BITS'(rxfer);
        slot_free = (state == CRED_IDLE) || cred_ready;
        flush_hit = (FLUSH_ON_LAST != 0) && rxfer && m_axis_tlast && (acc_next != '0);
        load      = slot_free && ((acc_next >= BATCH) || flush_hit);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= CRED_IDLE;
            acc      <= '0;
            cred_cnt <= '0;
            cred_ovf <= 1'b0;
        end else begin
            if (acc_sat) begin
                cred_ovf <= 1'b1;
            end
            if (load) begin
                acc      <= '0;
                cred_cnt <= acc_next;
                state    <= CRED_PEND;
            end else begin
                acc <= acc_next;
                if (state == CRED_PEND && cred_ready) begin
                    state <= CRED_IDLE;
                end
            end
        end
    end

    assign cred_valid = (state == CRED_PEND);

endmodule

// File: tb/tb_data_queue_credit_return.sv
// Directed bench for data_queue_credit_return: queue ordering, full/empty edges, credit batching.
module tb_data_queue_credit_return;
    import data_queue_credit_return_pkg::*;

    localparam int DATA_BITS = 512;
    localparam int KEEP_BITS = DATA_BITS / 8;
    localparam int DEPTH     = 64;
    localparam int CNT_BITS  = $clog2(DEPTH) + 1;

    logic                 aclk = 1'b0;
    logic                 aresetn;
    logic                 s_tvalid, s_tready, s_tlast;
    logic [DATA_BITS-1:0] s_tdata;
    logic [KEEP_BITS-1:0] s_tkeep;
    logic                 m_tvalid, m_tready, m_tlast;
    logic [DATA_BITS-1:0] m_tdata;
    logic [KEEP_BITS-1:0] m_tkeep;
    logic                 wxfer, rxfer;
    logic                 cred_valid, cred_ready, cred_ovf;
    logic [CNT_BITS-1:0]  cred_cnt, occupancy;

    int        checks   = 0;
    int        failures = 0;
    int        nw = 0, nr = 0, n_ret = 0, tot_ret = 0;
    cred_cnt_t last_cnt = '0;

    always #5 aclk = ~aclk;

    data_queue_credit_return #(
        .DATA_BITS     (DATA_BITS),
        .DEPTH         (DEPTH),
        .CRED_BATCH    (8),
        .FLUSH_ON_LAST (1)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .wxfer         (wxfer),
        .rxfer         (rxfer),
        .cred_valid    (cred_valid),
        .cred_ready    (cred_ready),
        .cred_cnt      (cred_cnt),
        .occupancy     (occupancy),
        .cred_ovf      (cred_ovf)
    );

    always @(posedge aclk) begin
        if (aresetn) begin
            if (wxfer) nw <= nw + 1;
            if (rxfer) nr <= nr + 1;
            if (cred_valid && cred_ready) begin
                n_ret    <= n_ret + 1;
                tot_ret  <= tot_ret + int'(cred_cnt);
                last_cnt <= cred_cnt;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [576:0] beat(input int i, input logic last);
        return {last, {8{i[7:0]}}, {16{i}}};
    endfunction

    task automatic drive(input logic v, input logic [576:0] w);
        s_tvalid = v;
        {s_tlast, s_tkeep, s_tdata} = w;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [576:0] obs, input logic [576:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int nw0, nr0, n0, t0, acc_cnt;
        logic [576:0] a5_beat;
        a5_beat = {1'b1, {KEEP_BITS{1'b1}}, {(DATA_BITS/8){8'hA5}}};

        aresetn = 1'b1;
        drive(1'b0, '0);
        m_tready = 1'b0;
        cred_ready = 1'b1;
        #1 aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        #1;
        chk("rst_s_tready", int'(s_tready), 1);
        chk("rst_m_tvalid", int'(m_tvalid), 0);
        chk("rst_occupancy", int'(occupancy), 0);
        chk("rst_cred_valid", int'(cred_valid), 0);
        chk("rst_cred_cnt", int'(cred_cnt), 0);
        chk("rst_cred_ovf", int'(cred_ovf), 0);
        @(negedge aclk);
        aresetn = 1'b1;

        // single beat round trip with tlast flush of one credit
        m_tready = 1'b1;
        nw0 = nw; nr0 = nr;
        @(negedge aclk);
        drive(1'b1, a5_beat);
        #1;
        chk("t1_wxfer", int'(wxfer), 1);
        chk("t1_no_passthru", int'(m_tvalid), 0);
        @(negedge aclk);
        drive(1'b0, '0);
        #1;
        chk("t1_m_tvalid", int'(m_tvalid), 1);
        chkd("t1_beat", {m_tlast, m_tkeep, m_tdata}, a5_beat);
        chk("t1_rxfer", int'(rxfer), 1);
        chk("t1_occ1", int'(occupancy), 1);
        @(negedge aclk);
        #1;
        chk("t1_occ0", int'(occupancy), 0);
        chk("t1_empty", int'(m_tvalid), 0);
        chk("t1_cred_valid", int'(cred_valid), 1);
        chk("t1_cred_cnt", int'(cred_cnt), 1);
        chk("t1_nw", nw - nw0, 1);
        chk("t1_nr", nr - nr0, 1);
        @(negedge aclk);
        #1;
        chk("t1_cred_drop", int'(cred_valid), 0);

        // three-beat packet: one return of 3 the cycle after tlast drains
        @(negedge aclk); drive(1'b1, beat(100, 1'b0));
        @(negedge aclk); drive(1'b1, beat(101, 1'b0));
        @(negedge aclk); drive(1'b1, beat(102, 1'b1));
        @(negedge aclk); drive(1'b0, '0);
        #1;
        chkd("t4_last_beat", {m_tlast, m_tkeep, m_tdata}, beat(102, 1'b1));
        chk("t4_rxfer", int'(rxfer), 1);
        chk("t4_no_early_cred", int'(cred_valid), 0);
        @(negedge aclk);
        #1;
        chk("t4_cred_valid", int'(cred_valid), 1);
        chk("t4_cred_cnt", int'(cred_cnt), 3);
        @(negedge aclk);
        #1;
        chk("t4_cred_drop", int'(cred_valid), 0);

        // 20 beats without tlast: two batches of 8, 4 left in the accumulator
        n0 = n_ret; t0 = tot_ret;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            drive(1'b1, beat(200 + i, 1'b0));
        end
        @(negedge aclk);
        drive(1'b0, '0);
        repeat (4) @(negedge aclk);
        #1;
        chk("t3_returns", n_ret - n0, 2);
        chk("t3_total", tot_ret - t0, 16);
        chk("t3_last_cnt", int'(last_cnt), 8);
        chk("t3_idle", int'(cred_valid), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            drive(1'b1, beat(220 + i, 1'b0));
        end
        @(negedge aclk);
        drive(1'b0, '0);
        repeat (4) @(negedge aclk);
        #1;
        chk("t3_residual_returns", n_ret - n0, 3);
        chk("t3_residual_cnt", int'(last_cnt), 8);
        chk("t3_residual_total", tot_ret - t0, 24);

        // fill to full with 70 attempted beats, then drain in order
        m_tready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge aclk);
            drive(1'b1, beat(300 + acc_cnt, 1'b0));
            #1;
            if (wxfer) acc_cnt++;
        end
        chk("t2_accepted", acc_cnt, 64);
        chk("t2_occ_full", int'(occupancy), 64);
        chk("t2_tready_full", int'(s_tready), 0);
        n0 = n_ret; t0 = tot_ret;
        @(negedge aclk);
        m_tready = 1'b1;
        drive(1'b1, beat(364, 1'b0));
        #1;
        chk("t2_full_read_tready", int'(s_tready), 0);
        chk("t2_full_read_wxfer", int'(wxfer), 0);
        chk("t2_full_read_rxfer", int'(rxfer), 1);
        chkd("t2_beat0", {m_tlast, m_tkeep, m_tdata}, beat(300, 1'b0));
        @(negedge aclk);
        drive(1'b0, '0);
        #1;
        chk("t2_tready_back", int'(s_tready), 1);
        chk("t2_occ63", int'(occupancy), 63);
        for (int j = 1; j < 64; j++) begin
            if (j > 1) begin
                @(negedge aclk);
                #1;
            end
            chkd("t2_order", {m_tlast, m_tkeep, m_tdata}, beat(300 + j, 1'b0));
        end
        @(negedge aclk);
        #1;
        chk("t2_empty", int'(m_tvalid), 0);
        chk("t2_occ0", int'(occupancy), 0);
        repeat (2) @(negedge aclk);
        #1;
        chk("t2_returns", n_ret - n0, 8);
        chk("t2_total", tot_ret - t0, 64);

        // credit back-pressure: 8 held stable, then 22 returned
        cred_ready = 1'b0;
        n0 = n_ret; t0 = tot_ret;
        for (int i = 0; i < 30; i++) begin
            @(negedge aclk);
            drive(1'b1, beat(500 + i, 1'b0));
            if (i == 20) begin
                #1;
                chk("t5_mid_valid", int'(cred_valid), 1);
                chk("t5_mid_cnt", int'(cred_cnt), 8);
            end
        end
        @(negedge aclk);
        drive(1'b0, '0);
        repeat (3) @(negedge aclk);
        #1;
        chk("t5_held_valid", int'(cred_valid), 1);
        chk("t5_held_cnt", int'(cred_cnt), 8);
        chk("t5_no_return", n_ret - n0, 0);
        @(negedge aclk);
        cred_ready = 1'b1;
        #1;
        chk("t5_hs_cnt", int'(cred_cnt), 8);
        @(negedge aclk);
        #1;
        chk("t5_reload_valid", int'(cred_valid), 1);
        chk("t5_reload_cnt", int'(cred_cnt), 22);
        @(negedge aclk);
        #1;
        chk("t5_drop", int'(cred_valid), 0);
        chk("t5_returns", n_ret - n0, 2);
        chk("t5_total", tot_ret - t0, 30);

        // full queue with a pending credit, then reset mid-stream
        cred_ready = 1'b0;
        m_tready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge aclk);
            drive(1'b1, beat(600 + i, 1'b0));
        end
        @(negedge aclk);
        drive(1'b0, '0);
        m_tready = 1'b1;
        repeat (8) @(negedge aclk);
        m_tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, beat(700 + i, 1'b0));
            @(negedge aclk);
        end
        drive(1'b0, '0);
        #1;
        chk("t6_occ_full", int'(occupancy), 64);
        chk("t6_pend_valid", int'(cred_valid), 1);
        chk("t6_pend_cnt", int'(cred_cnt), 8);
        @(negedge aclk);
        m_tready = 1'b1;
        drive(1'b1, beat(710, 1'b0));
        #2 aresetn = 1'b0;
        #1;
        chk("t6_rst_m_tvalid", int'(m_tvalid), 0);
        chk("t6_rst_s_tready", int'(s_tready), 1);
        chk("t6_rst_occ", int'(occupancy), 0);
        chk("t6_rst_cred_valid", int'(cred_valid), 0);
        chk("t6_rst_cred_cnt", int'(cred_cnt), 0);
        chk("t6_rst_rxfer", int'(rxfer), 0);
        drive(1'b0, '0);
        cred_ready = 1'b1;
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        drive(1'b1, beat(777, 1'b1));
        @(negedge aclk);
        drive(1'b0, '0);
        #1;
        chk("t6_post_valid", int'(m_tvalid), 1);
        chkd("t6_post_beat", {m_tlast, m_tkeep, m_tdata}, beat(777, 1'b1));
        @(negedge aclk);
        #1;
        chk("t6_post_cred_valid", int'(cred_valid), 1);
        chk("t6_post_cred_cnt", int'(cred_cnt), 1);
        chk("t6_post_occ", int'(occupancy), 0);
        chk("t6_ovf_clear", int'(cred_ovf), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
